// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Imported by the controller and its datapath step.
package muldiv_pkg;

  localparam int ITERS_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
// Purely combinational; the controller registers acc_next.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  acc,
  input  logic [WIDTH-1:0]  opnd,
  input  logic              div_mode,
  output logic [2*WIDTH:0]  acc_next
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    sh   = {acc[2*WIDTH-1:0], 1'b0};
    diff = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, opnd};
    acc_next = acc;
    if (div_mode) begin
      // borrow out means the trial subtract failed: keep the shifted value
      if (diff[WIDTH+1])
        acc_next = sh;
      else
        acc_next = {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
    end else begin
      if (acc[0])
        acc_next = {1'b0, sum, acc[WIDTH-1:1]};
      else
        acc_next = {2'b00, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Stalls EX-stage HI/LO consumers and new mul/div ops while busy.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = ITERS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mf_req_i,
  input  logic             mt_hi_i,
  input  logic             mt_lo_i,
  input  logic [WIDTH-1:0] mt_data_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_e state, state_nxt;

  logic [CW-1:0]    count;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_step;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_raw;
  logic             div_q;
  logic             neg_res;
  logic             neg_rem;
  logic             b_zero;

  logic             accept;
  logic             mt_ok;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign accept = (state == S_IDLE) & start_i & ~flush_i;
  assign mt_ok  = (state == S_IDLE) & ~flush_i;

  assign a_neg = op_is_signed(op_i) & a_i[WIDTH-1];
  assign b_neg = op_is_signed(op_i) & b_i[WIDTH-1];
  assign a_mag = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_mag = b_neg ? (~b_i + 1'b1) : b_i;

  assign prod_fix = neg_res ? (~acc[2*WIDTH-1:0] + 1'b1)
                            : acc[2*WIDTH-1:0];
  assign quot_fix = neg_res ? (~acc[WIDTH-1:0] + 1'b1)
                            : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1)
                            : acc[2*WIDTH-1:WIDTH];

  assign busy_o  = (state != S_IDLE);
  assign stall_o = busy_o & (mf_req_i | start_i | mt_hi_i | mt_lo_i);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .div_mode (div_q),
    .acc_next (acc_step)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = S_ITER;
      S_ITER: begin
        if (flush_i)
          state_nxt = S_IDLE;
        else if (count == LAST)
          state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      a_raw   <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (mt_ok && mt_hi_i) hi_o <= mt_data_i;
      if (mt_ok && mt_lo_i) lo_o <= mt_data_i;
      if (accept) begin
        // multiplier rides in the low half; dividend for divide
        count   <= '0;
        div_q   <= op_is_div(op_i);
        acc     <= {{(WIDTH+1){1'b0}},
                    op_is_div(op_i) ? a_mag : b_mag};
        opnd    <= op_is_div(op_i) ? b_mag : a_mag;
        a_raw   <= a_i;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        b_zero  <= (b_i == '0);
      end
      if (state == S_ITER && !flush_i) begin
        acc   <= acc_step;
        count <= count + 1'b1;
      end
      if (state == S_FIX && !flush_i) begin
        done_o <= 1'b1;
        if (!div_q) begin
          hi_o <= prod_fix[2*WIDTH-1:WIDTH];
          lo_o <= prod_fix[WIDTH-1:0];
        end else if (b_zero) begin
          hi_o <= a_raw;
          lo_o <= '1;
        end else begin
          hi_o <= rem_fix;
          lo_o <= quot_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl against an arithmetic HI/LO model.
// Directed cases, stall/flush/mt scenarios, random ops, async reset.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        mf_req_i = 1'b0;
  logic        mt_hi_i = 1'b0;
  logic        mt_lo_i = 1'b0;
  logic [31:0] mt_data_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        done_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .mf_req_i  (mf_req_i),
    .mt_hi_i   (mt_hi_i),
    .mt_lo_i   (mt_lo_i),
    .mt_data_i (mt_data_i),
    .flush_i   (flush_i),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .stall_o   (stall_o)
  );

  function automatic logic [63:0] ref_model(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, q, r, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      2'd0: p = sa * sb;
      2'd1: p = ua * ub;
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = ua / ub;
        r = ua % ub;
        p = {r[31:0], q[31:0]};
      end
    endcase
    return p;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string nm);
    logic [63:0] r;
    int busy_n, done_n, done_k;
    logic held_bad;
    r = ref_model(op, a, b);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    busy_n = 0; done_n = 0; done_k = 0; held_bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (busy_o) busy_n++;
      if (done_o) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      if (k < 34 && (hi_o !== exp_hi || lo_o !== exp_lo)) held_bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (done_k != 34) begin
      errors++;
      $display("FAIL %s latency: done at cycle %0d, want 34", nm, done_k);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d, want 1", nm, done_n);
    end
    checks++;
    if (busy_n != 33) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, want 33", nm, busy_n);
    end
    checks++;
    if (held_bad) begin
      errors++;
      $display("FAIL %s hilo_hold: changed while busy, want %h/%h",
               nm, exp_hi, exp_lo);
    end
    checks++;
    if (hi_o !== r[63:32] || lo_o !== r[31:0]) begin
      errors++;
      $display("FAIL %s result: hi=%h lo=%h, want hi=%h lo=%h",
               nm, hi_o, lo_o, r[63:32], r[31:0]);
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (hi_o !== 0 || lo_o !== 0 || busy_o !== 0 ||
        done_o !== 0 || stall_o !== 0) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b stall=%b, want 0",
               hi_o, lo_o, busy_o, done_o, stall_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(2'd0, 32'd6, 32'hFFFF_FFF9, "mult_6_m7");
    run_op(2'd3, 32'd100, 32'd7, "divu_100_7");
    run_op(2'd2, 32'hFFFF_FFF1, 32'd4, "div_m15_4");
    run_op(2'd2, 32'd123, 32'd0, "div_by_zero");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
  endtask

  task automatic test_stall();
    int stall_n;
    logic [63:0] r;
    r = ref_model(2'd1, 32'h1_0000, 32'h1_0000);
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd1; a_i = 32'h1_0000; b_i = 32'h1_0000;
    @(posedge clk);
    @(negedge clk);
    mf_req_i = 1'b1;
    stall_n = 0;
    for (int k = 1; k <= 33; k++) begin
      if (stall_o) stall_n++;
      @(negedge clk);
    end
    checks++;
    if (stall_n != 33) begin
      errors++;
      $display("FAIL stall_cycles: got %0d, want 33", stall_n);
    end
    checks++;
    if (stall_o !== 1'b0 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: stall=%b done=%b, want 0/1",
               stall_o, done_o);
    end
    checks++;
    if (hi_o !== r[63:32] || lo_o !== r[31:0]) begin
      errors++;
      $display("FAIL mflo_fresh: hi=%h lo=%h, want %h/%h",
               hi_o, lo_o, r[63:32], r[31:0]);
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    @(negedge clk);
    start_i = 1'b0;
    mf_req_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL held_start: busy=%b, want 1", busy_o);
    end
    for (int j = 0; j < 40 && !done_o; j++) @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || hi_o !== r[63:32] || lo_o !== r[31:0]) begin
      errors++;
      $display("FAIL held_result: done=%b hi=%h lo=%h, want 1 %h %h",
               done_o, hi_o, lo_o, r[63:32], r[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_mt_flush();
    logic seen_done;
    @(negedge clk);
    mt_lo_i = 1'b1; mt_data_i = 32'd55;
    @(negedge clk);
    mt_lo_i = 1'b0;
    checks++;
    if (lo_o !== 32'd55 || hi_o !== exp_hi) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h, want %h/00000037", hi_o, lo_o, exp_hi);
    end
    exp_lo = 32'd55;
    mt_hi_i = 1'b1; mt_lo_i = 1'b1; mt_data_i = 32'h1234;
    flush_i = 1'b1; start_i = 1'b1; op_i = 2'd3; a_i = 32'd9; b_i = 32'd2;
    @(negedge clk);
    mt_hi_i = 1'b0; mt_lo_i = 1'b0; flush_i = 1'b0; start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || hi_o !== exp_hi || lo_o !== exp_lo) begin
      errors++;
      $display("FAIL flush_idle_block: busy=%b hi=%h lo=%h, want 0 %h %h",
               busy_o, hi_o, lo_o, exp_hi, exp_lo);
    end
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 1; k < 5; k++) @(negedge clk);
    mt_hi_i = 1'b1; mt_data_i = 32'hDEAD;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL mthi_busy_stall: stall=%b, want 1", stall_o);
    end
    @(negedge clk);
    mt_hi_i = 1'b0;
    for (int k = 6; k < 10; k++) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_iter: busy=%b done=%b, want 0/0", busy_o, done_o);
    end
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done_o) seen_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_done || hi_o !== exp_hi || lo_o !== 32'd55) begin
      errors++;
      $display("FAIL flush_no_write: done_seen=%b hi=%h lo=%h, want 0 %h 00000037",
               seen_done, hi_o, lo_o, exp_hi);
    end
    mt_hi_i = 1'b1; mt_lo_i = 1'b1; mt_data_i = 32'hA5A5;
    start_i = 1'b1; op_i = 2'd3; a_i = 32'd9; b_i = 32'd2;
    @(negedge clk);
    mt_hi_i = 1'b0; mt_lo_i = 1'b0; start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || hi_o !== 32'hA5A5 || lo_o !== 32'hA5A5) begin
      errors++;
      $display("FAIL mt_with_start: busy=%b hi=%h lo=%h, want 1 0000a5a5 0000a5a5",
               busy_o, hi_o, lo_o);
    end
    for (int j = 0; j < 40 && !done_o; j++) @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || hi_o !== 32'd1 || lo_o !== 32'd4) begin
      errors++;
      $display("FAIL fix_overrides_mt: done=%b hi=%h lo=%h, want 1 1 4",
               done_o, hi_o, lo_o);
    end
    exp_hi = 32'd1;
    exp_lo = 32'd4;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, "random");
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd0; a_i = 32'd7; b_i = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    mf_req_i = 1'b1;
    for (int k = 1; k < 6; k++) @(negedge clk);
    checks++;
    if (stall_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy: stall=%b busy=%b, want 1/1",
               stall_o, busy_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (hi_o !== 0 || lo_o !== 0 || busy_o !== 0 ||
        done_o !== 0 || stall_o !== 0) begin
      errors++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b stall=%b, want 0",
               hi_o, lo_o, busy_o, done_o, stall_o);
    end
    @(negedge clk);
    rst = 1'b0;
    mf_req_i = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    run_op(2'd0, 32'd3, 32'd5, "mult_after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_mt_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the 5-stage MIPS pipeline, driven from the EX stage.
- Executes MULT, MULTU, DIV and DIVU over 32 iterations, one bit per cycle.
- Owns the HI/LO registers and services MFHI, MFLO, MTHI and MTLO.
- Raises a stall to the hazard logic whenever a HI/LO consumer or a new mul/div arrives while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITERS, 32, iteration count; must equal WIDTH.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  EX holds a MULT/MULTU/DIV/DIVU this cycle.
- op_i  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- a_i  in  WIDTH  rs value (multiplicand / dividend).
- b_i  in  WIDTH  rt value (multiplier / divisor).
- mf_req_i  in  1  EX holds MFHI/MFLO.
- mt_hi_i  in  1  MTHI write request.
- mt_lo_i  in  1  MTLO write request.
- mt_data_i  in  WIDTH  MTHI/MTLO data.
- flush_i  in  1  squash the in-flight operation (exception or branch kill).
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.
- busy_o  out  1  operation in flight.
- done_o  out  1  one-cycle pulse when HI/LO are updated by mul/div.
- stall_o  out  1  combinational stall request to the hazard unit.

Behaviour:
- Reset: state=IDLE; hi_o=0, lo_o=0, busy_o=0, done_o=0, stall_o=0; count=0. Reset mid-operation aborts it with no HI/LO write.
- States: IDLE, ITER, FIX.
  - IDLE: start_i & !flush_i at edge N latches |a|, |b| (magnitudes for signed ops), result-sign flags, op and count=0, then goes to ITER.
  - ITER: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. Leaves for FIX at the edge where count reaches ITERS-1, i.e. edge N+32.
  - FIX: edge N+33 applies two's-complement correction, writes HI/LO, returns to IDLE. done_o is high in the cycle after edge N+33.
- busy_o = (state != IDLE). It is high in cycles N+1 through N+33.
- Result latency is 34 edges from acceptance. HI/LO values hold unchanged while busy.
- Results:
  - Multiply: {HI,LO} = 64-bit product.
  - Divide: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - Divide by zero: LO=all ones, HI=a_i (raw dividend). Still takes the full 34-edge latency.
  - Signed corner 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- stall_o = busy_o & (mf_req_i | start_i | mt_hi_i | mt_lo_i). It drops combinationally in the IDLE cycle after FIX, so MFHI/MFLO read the fresh hi_o/lo_o that cycle.
- MTHI/MTLO write at the edge only when state=IDLE; if both are asserted, both registers are written. If mt_* and start_i coincide in IDLE, the mt write happens and start is accepted; the later FIX write overrides it.
- flush_i: in ITER/FIX, return to IDLE at the next edge with no HI/LO write and no done_o. In IDLE, flush_i blocks acceptance of start_i and of mt_* writes.
- start_i while busy is not accepted; the stall holds the instruction in EX until IDLE.
- Width rules: the internal accumulator is 2*WIDTH+1 bits. The divide partial remainder is WIDTH+1 bits; the carry-out bit selects restore.

Decomposition:
- Shared package/include muldiv_pkg holds:
  - op encodings (OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3);
  - state encodings (S_IDLE, S_ITER, S_FIX);
  - ITERS_DEFAULT.
- Sub-module muldiv_step is purely combinational: one iteration of shift-add or restoring shift-subtract. It takes the accumulator, operand and mode, and returns the next accumulator. muldiv_ctrl holds the FSM, counter, sign fixup, HI/LO and stall logic.

Test Plan:
- MULT a=6, b=0xFFFFFFF9 (-7) -> after 34 edges HI=0xFFFFFFFF, LO=0xFFFFFFD6; done_o pulses exactly once; busy_o high for 33 cycles.
- DIVU a=100, b=7 -> LO=14, HI=2. DIV a=0xFFFFFFF1 (-15), b=4 -> LO=0xFFFFFFFD, HI=0xFFFFFFFD.
- DIV a=123, b=0 -> LO=0xFFFFFFFF, HI=123, latency unchanged. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MFLO asserted the cycle after MULTU 0x10000 x 0x10000 is accepted -> stall_o high for 33 cycles, low in the first IDLE cycle with HI=1, LO=0; a second start_i during busy is held, not accepted.
- MTLO 55 in IDLE, then DIVU 9/2 flushed at iteration 10 -> IDLE next edge, LO=55, HI unchanged, no done_o; MTHI asserted while busy -> stall_o=1, HI not written.
- Reset asserted mid-ITER (asynchronously, between edges) -> outputs immediately 0, state IDLE; after release, a new MULT 3x5 gives LO=15, HI=0.
